// File: rtl/d_cache_responder.sv
// Direct-mapped data-cache responder with a write-through, no-allocate store path.
// Line fills and store drains use a req/gnt protocol to a backing memory.
module d_cache_responder #(
  parameter int unsigned DATA_WIDTH  = 32,
  parameter int unsigned ADDR_WIDTH  = 30,
  parameter int unsigned INDEX_WIDTH = 5,
  parameter int unsigned LINE_WORDS  = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  req_valid,
  input  logic                  req_mem_action,
  input  logic [ADDR_WIDTH-1:0] req_addr,
  input  logic [DATA_WIDTH-1:0] req_data,
  output logic                  out_valid,
  output logic [DATA_WIDTH-1:0] out_data,
  output logic                  mem_rd_req,
  output logic [ADDR_WIDTH-1:0] mem_rd_addr,
  input  logic                  mem_rd_gnt,
  input  logic                  mem_rd_beat,
  input  logic [DATA_WIDTH-1:0] mem_rd_data,
  output logic                  mem_wr_req,
  output logic [ADDR_WIDTH-1:0] mem_wr_addr,
  output logic [DATA_WIDTH-1:0] mem_wr_data,
  input  logic                  mem_wr_gnt
);

  localparam int unsigned OFF_W  = $clog2(LINE_WORDS);
  localparam int unsigned SEL_W  = INDEX_WIDTH + OFF_W;
  localparam int unsigned TAG_W  = ADDR_WIDTH - SEL_W;
  localparam int unsigned LINES  = 1 << INDEX_WIDTH;
  localparam int unsigned WORDS  = LINES * LINE_WORDS;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    FILL_REQ = 2'd1,
    FILL     = 2'd2
  } state_t;

  state_t                  state_q, state_d;
  logic [OFF_W-1:0]        count_q;
  logic [LINES-1:0]        valid_q;
  logic [TAG_W-1:0]        tag_mem  [LINES];
  logic [DATA_WIDTH-1:0]   data_mem [WORDS];
  logic                    sb_full_q;
  logic [ADDR_WIDTH-1:0]   sb_addr_q;
  logic [DATA_WIDTH-1:0]   sb_data_q;

  logic [INDEX_WIDTH-1:0]  index;
  logic [TAG_W-1:0]        tag;
  logic [SEL_W-1:0]        word_sel;
  logic [SEL_W-1:0]        fill_sel;
  logic                    hit;
  logic                    rd_hit;
  logic                    st_accept;
  logic                    fill_beat;
  logic                    fill_done;

  // The requester holds its address for the whole miss, so it also addresses the fill.
  assign index    = req_addr[OFF_W +: INDEX_WIDTH];
  assign tag      = req_addr[ADDR_WIDTH-1 -: TAG_W];
  assign word_sel = req_addr[SEL_W-1:0];
  assign fill_sel = {index, count_q};
  assign hit      = valid_q[index] && (tag_mem[index] == tag);

  // Next-state and per-cycle decisions.
  always_comb begin
    state_d   = state_q;
    rd_hit    = 1'b0;
    st_accept = 1'b0;
    fill_beat = 1'b0;
    fill_done = 1'b0;
    case (state_q)
      IDLE: begin
        if (req_valid) begin
          if (!req_mem_action) begin
            if (hit) begin
              rd_hit = 1'b1;
            end else if (!sb_full_q) begin
              // A pending store must reach memory before a miss may fetch.
              state_d = FILL_REQ;
            end
          end else if (!sb_full_q) begin
            st_accept = 1'b1;
          end
        end
      end
      FILL_REQ: begin
        if (mem_rd_gnt) state_d = FILL;
      end
      FILL: begin
        if (mem_rd_beat) begin
          fill_beat = 1'b1;
          if (count_q == OFF_W'(LINE_WORDS - 1)) begin
            fill_done = 1'b1;
            state_d   = IDLE;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Control state, valid bits and store buffer.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      count_q   <= '0;
      valid_q   <= '0;
      sb_full_q <= 1'b0;
      sb_addr_q <= '0;
      sb_data_q <= '0;
    end else begin
      state_q <= state_d;
      if (state_q == FILL_REQ && mem_rd_gnt) begin
        count_q <= '0;
      end else if (fill_beat) begin
        count_q <= count_q + OFF_W'(1);
      end
      if (fill_done) valid_q[index] <= 1'b1;
      if (st_accept) begin
        sb_full_q <= 1'b1;
        sb_addr_q <= req_addr;
        sb_data_q <= req_data;
      end else if (sb_full_q && mem_wr_gnt) begin
        sb_full_q <= 1'b0;
      end
    end
  end

  // Tag and data arrays; writes suppressed while reset is asserted.
  always_ff @(posedge clk) begin
    if (rst_n) begin
      if (fill_beat) data_mem[fill_sel] <= mem_rd_data;
      if (fill_done) tag_mem[index] <= tag;
      if (st_accept && hit) data_mem[word_sel] <= req_data;
    end
  end

  assign out_valid   = rst_n && (rd_hit || st_accept);
  assign out_data    = (rst_n && rd_hit) ? data_mem[word_sel] : '0;
  assign mem_rd_req  = rst_n && (state_q == FILL_REQ);
  assign mem_rd_addr = mem_rd_req ? {req_addr[ADDR_WIDTH-1:OFF_W], OFF_W'(0)} : '0;
  assign mem_wr_req  = rst_n && sb_full_q;
  assign mem_wr_addr = mem_wr_req ? sb_addr_q : '0;
  assign mem_wr_data = mem_wr_req ? sb_data_q : '0;

endmodule

// File: tb/tb_d_cache_responder.sv
// Scoreboard bench for d_cache_responder: directed requests, a backing-memory
// model with configurable grant delay and beat gaps, and a response monitor.
module tb_d_cache_responder;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        req_valid;
  logic        req_mem_action;
  logic [29:0] req_addr;
  logic [31:0] req_data;
  logic        out_valid;
  logic [31:0] out_data;
  logic        mem_rd_req;
  logic [29:0] mem_rd_addr;
  logic        mem_rd_gnt;
  logic        mem_rd_beat;
  logic [31:0] mem_rd_data;
  logic        mem_wr_req;
  logic [29:0] mem_wr_addr;
  logic [31:0] mem_wr_data;
  logic        mem_wr_gnt;

  d_cache_responder dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_mem_action(req_mem_action),
    .req_addr(req_addr), .req_data(req_data),
    .out_valid(out_valid), .out_data(out_data),
    .mem_rd_req(mem_rd_req), .mem_rd_addr(mem_rd_addr),
    .mem_rd_gnt(mem_rd_gnt), .mem_rd_beat(mem_rd_beat), .mem_rd_data(mem_rd_data),
    .mem_wr_req(mem_wr_req), .mem_wr_addr(mem_wr_addr), .mem_wr_data(mem_wr_data),
    .mem_wr_gnt(mem_wr_gnt)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;
  logic [31:0] exp_q[$];

  // Backing memory model state.
  logic [31:0] mem [2048];
  int   gap      = 0;
  int   wr_delay = 0;
  int   wr_cnt   = 0;
  int   fills    = 0;
  int   rd_cycles = 0;
  int   overlap  = 0;
  logic [29:0] last_rd_addr = '0;
  bit   fill_active = 0;
  logic [29:0] fill_addr;
  int   fill_idx, gap_cnt;

  initial begin
    for (int i = 0; i < 2048; i++) mem[i] = 32'h5000_0000 + 32'(i);
    for (int i = 0; i < 4; i++) mem[32'h40 + i] = 32'hA0 + 32'(i);
    mem_rd_gnt = 0; mem_rd_beat = 0; mem_rd_data = '0; mem_wr_gnt = 0;
    forever begin
      @(posedge clk); #1;
      mem_rd_gnt = 0; mem_rd_beat = 0; mem_rd_data = '0; mem_wr_gnt = 0;
      if (mem_wr_req) begin
        if (wr_cnt >= wr_delay) begin
          mem_wr_gnt = 1;
          mem[mem_wr_addr[10:0]] = mem_wr_data;
          wr_cnt = 0;
        end else begin
          wr_cnt++;
        end
      end
      if (fill_active) begin
        if (gap_cnt > 0) begin
          gap_cnt--;
        end else begin
          mem_rd_beat = 1;
          mem_rd_data = mem[fill_addr[10:0] + 11'(fill_idx)];
          fill_idx++;
          gap_cnt = gap;
          if (fill_idx == 4) fill_active = 0;
        end
      end else if (mem_rd_req) begin
        mem_rd_gnt  = 1;
        fill_active = 1;
        fill_addr   = mem_rd_addr;
        fill_idx    = 0;
        gap_cnt     = 0;
        fills++;
      end
    end
  end

  // Response monitor: every accepted request pops one expectation.
  always @(negedge clk) begin
    if (mem_rd_req) begin
      rd_cycles++;
      last_rd_addr = mem_rd_addr;
    end
    if (mem_rd_req && mem_wr_req) overlap++;
    if (rst_n && req_valid && out_valid) begin
      total++;
      if (exp_q.size() == 0) begin
        bad++;
        $display("FAIL resp_unexpected addr=%h got=%h", req_addr, out_data);
      end else begin
        logic [31:0] e;
        e = exp_q.pop_front();
        if (out_data !== e) begin
          bad++;
          $display("FAIL resp addr=%h got=%h exp=%h", req_addr, out_data, e);
        end
      end
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk); #1;
  endtask

  // Called just after a rising edge; returns just after a rising edge with req dropped.
  task automatic do_req(input logic act, input logic [29:0] a, input logic [31:0] d,
                        input logic [31:0] exp, input int budget, output int lat);
    req_valid = 1; req_mem_action = act; req_addr = a; req_data = d;
    exp_q.push_back(exp);
    lat = -1;
    for (int k = 0; k <= budget; k++) begin
      @(negedge clk);
      if (out_valid) begin
        lat = k;
        break;
      end
      tick();
    end
    if (lat < 0) begin
      total++; bad++;
      $display("FAIL timeout addr=%h got=none exp=response", a);
      if (exp_q.size() > 0) void'(exp_q.pop_back());
    end
    tick();
    req_valid = 0; req_mem_action = 0; req_data = '0;
  endtask

  int lat, f0, r0;

  initial begin
    rst_n = 0; req_valid = 0; req_mem_action = 0; req_addr = '0; req_data = '0;
    repeat (3) tick();
    @(negedge clk);
    check("rst_out_valid", 32'(out_valid), 0);
    check("rst_rd_req", 32'(mem_rd_req), 0);
    check("rst_wr_req", 32'(mem_wr_req), 0);
    tick(); rst_n = 1; tick();
    @(negedge clk);
    check("post_rst_out_data", out_data, 0);
    check("post_rst_rd_req", 32'(mem_rd_req), 0);
    tick();

    // Cold miss then same-line hit.
    f0 = fills; r0 = rd_cycles;
    do_req(0, 30'h40, 0, 32'hA0, 40, lat);
    check("miss_lat", 32'(lat), 6);
    check("miss_fills", 32'(fills - f0), 1);
    check("miss_rd_cycles", 32'(rd_cycles - r0), 1);
    check("miss_rd_addr", 32'(last_rd_addr), 32'h40);
    do_req(0, 30'h43, 0, 32'hA3, 40, lat);
    check("hit_lat", 32'(lat), 0);

    // Conflict miss replaces the line; original line misses again.
    f0 = fills;
    do_req(0, 30'hC2, 0, 32'h5000_00C2, 40, lat);
    check("conflict_lat", 32'(lat), 6);
    check("conflict_rd_addr", 32'(last_rd_addr), 32'hC0);
    do_req(0, 30'h40, 0, 32'hA0, 40, lat);
    check("reread_lat", 32'(lat), 6);
    check("reread_fills", 32'(fills - f0), 2);

    // Store hit updates the line and drains write-through.
    do_req(1, 30'h41, 32'hDEAD, 0, 40, lat);
    check("st_hit_lat", 32'(lat), 0);
    @(negedge clk);
    check("st_wr_req", 32'(mem_wr_req), 1);
    check("st_wr_addr", 32'(mem_wr_addr), 32'h41);
    check("st_wr_data", mem_wr_data, 32'hDEAD);
    tick(); tick();
    do_req(0, 30'h41, 0, 32'hDEAD, 40, lat);
    check("ld_after_st_lat", 32'(lat), 0);

    // Store miss does not allocate; later load fetches the drained value.
    f0 = fills;
    do_req(1, 30'h200, 32'h1234, 0, 40, lat);
    check("st_miss_lat", 32'(lat), 0);
    repeat (3) tick();
    check("st_miss_no_fill", 32'(fills - f0), 0);
    do_req(0, 30'h200, 0, 32'h1234, 40, lat);
    check("st_miss_ld_lat", 32'(lat), 6);

    // Slow drain: second store and a miss both wait for the buffer to empty.
    wr_delay = 5;
    do_req(1, 30'h80, 32'h11, 0, 40, lat);
    check("slow_st1_lat", 32'(lat), 0);
    do_req(1, 30'h84, 32'h22, 0, 40, lat);
    check("slow_st2_lat", 32'(lat), 6);
    do_req(0, 30'h100, 0, 32'h5000_0100, 60, lat);
    check("slow_miss_lat", 32'(lat), 12);
    wr_delay = 0;
    repeat (8) tick();
    check("mem_80", mem[11'h80], 32'h11);
    check("mem_84", mem[11'h84], 32'h22);

    // Fill with two idle cycles between beats.
    gap = 2;
    do_req(0, 30'h300, 0, 32'h5000_0300, 60, lat);
    check("gap_lat", 32'(lat), 12);
    gap = 0;
    do_req(0, 30'h303, 0, 32'h5000_0303, 40, lat);
    check("gap_w3_lat", 32'(lat), 0);
    do_req(0, 30'h301, 0, 32'h5000_0301, 40, lat);
    check("gap_w1_lat", 32'(lat), 0);

    // Reset after two beats abandons the fill; stray beats are ignored.
    req_valid = 1; req_mem_action = 0; req_addr = 30'h400;
    repeat (4) tick();
    rst_n = 0; req_valid = 0;
    @(negedge clk);
    check("midrst_out_valid", 32'(out_valid), 0);
    check("midrst_rd_req", 32'(mem_rd_req), 0);
    tick(); rst_n = 1;
    @(negedge clk);
    check("afterrst_rd_req", 32'(mem_rd_req), 0);
    repeat (3) tick();
    f0 = fills;
    do_req(0, 30'h400, 0, 32'h5000_0400, 40, lat);
    check("refill_lat", 32'(lat), 6);
    check("refill_fills", 32'(fills - f0), 1);
    do_req(0, 30'h402, 0, 32'h5000_0402, 40, lat);
    check("refill_w2_lat", 32'(lat), 0);
    f0 = fills;
    do_req(0, 30'h41, 0, 32'hDEAD, 40, lat);
    check("post_rst_miss_lat", 32'(lat), 6);

    repeat (3) tick();
    check("no_rd_wr_overlap", 32'(overlap), 0);
    check("queue_empty", 32'(exp_q.size()), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
